adder_nbit_tb_seq_driver: RTL and testbench
===========================================

Name: adder_nbit_tb_seq_driver

Overview:
Clocked, parametrised stimulus and checker engine for N-bit adders under test. It is the successor of the fixed 4-bit delay-based driver. It sweeps every {c_in, A, B} combination in order, waits a programmable settle time, and compares sum/c_out against an internal golden add. It also counts failures, captures the first failing vector, and flags completion, so benches and mixed-signal sims can run unattended.

Parameters:
WIDTH, 4, operand and sum width in bits (1..12)
SETTLE, 2, clock cycles between driving a vector and sampling DUT outputs (>=1)
CNT_W, 16, width of fail_count; saturating

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE or DONE
sum  input  WIDTH  DUT sum
c_out  input  1  DUT carry out
A_data  output  WIDTH  operand A to DUT
B_data  output  WIDTH  operand B to DUT
c_in  output  1  carry in to DUT
busy  output  1  high during sweep
done  output  1  high after sweep ends, until next start/reset
pass  output  1  valid when done: 1 iff fail_count==0
fail_count  output  CNT_W  mismatches seen, saturates at all-ones
first_fail_vec  output  2*WIDTH+1  {c_in,A,B} of first mismatch; 0 if none
first_fail_valid  output  1  first_fail_vec holds a captured vector

Behaviour:
- Single clock domain. Reset is synchronous and active-high; polarity and synchronicity are fixed.
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-sweep aborts the sweep on that edge and returns everything to reset values.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - clear fail_count, first_fail_*, done, pass
  - drive vector {c_in,A,B}=0
  - load settle counter with SETTLE; go to SETTLE; busy=1
- SETTLE: decrement counter; after SETTLE cycles in this state, go to CHECK. Vector outputs hold stable.
- CHECK (one cycle):
  - expected = A_data + B_data + c_in, computed WIDTH+1 bits wide
  - mismatch if sum != expected[WIDTH-1:0] or c_out != expected[WIDTH]
  - on mismatch: fail_count increments, saturating
  - on the first mismatch only: capture first_fail_vec and set first_fail_valid
  - if vector is not the last: advance {c_in,A,B} as one (2*WIDTH+1)-bit counter (B fastest, c_in slowest), reload counter, go to SETTLE
  - last vector is all-ones: go to DONE
- DONE: busy=0, done=1, pass=(fail_count==0). Outputs hold the last vector.
- Cost: SETTLE+1 cycles per vector, 2^(2*WIDTH+1) vectors in total.
- done rises 2^(2*WIDTH+1)*(SETTLE+1) cycles after the start edge.
- start while busy is ignored.
- start in DONE restarts the sweep.
- fail_count saturation does not stop the sweep.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: on the first mismatch in CHECK, go directly to DONE (pass=0, fail_count=1). DUT inputs hold the failing vector for waveform debug.
- Undefined: the full sweep always completes.

Test Plan:
- WIDTH=4, SETTLE=2, correct adder, pulse start:
  - busy for 1536 cycles; then done=1, pass=1, fail_count=0, first_fail_valid=0.
- Same setup, DUT c_out stuck-at-0:
  - done with pass=0, fail_count=256
  - first_fail_vec = {0, 4'd1, 4'd15}
- Same setup, DUT sum[0] stuck-at-0:
  - fail_count=256
  - first_fail_vec = {0, 4'd0, 4'd1}
- Assert reset at cycle 700 of a sweep:
  - next cycle all outputs 0, state IDLE.
  - a new start gives the full 1536-cycle sweep with a clean result.
- start pulsed again at cycle 100 while busy:
  - ignored; done still at cycle 1536.
  - then start in DONE: done/pass/fail_count clear, sweep reruns.
- STOP_ON_FAIL_EN defined, c_out stuck-at-0:
  - done asserts after vector {0,1,15}; fail_count=1, pass=0.
  - A_data=1, B_data=15, c_in=0 held.

Source files
------------

// File: rtl/adder_nbit_tb_seq_driver_if.sv
// Operand/result bus between the sweep driver and an N-bit adder under test.
// The master drives operands and carry in; the slave returns sum and carry out.
interface adder_nbit_tb_seq_driver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A_data;
    logic [WIDTH-1:0] B_data;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output A_data, B_data, c_in,
        input  sum, c_out
    );

    modport slave (
        input  A_data, B_data, c_in,
        output sum, c_out
    );
endinterface

// File: rtl/adder_nbit_tb_seq_driver.sv
// Exhaustive {c_in,A,B} sweep driver and checker for an N-bit adder, with a programmable settle time.
// Optional macro STOP_ON_FAIL_EN: finish on the first mismatch and hold the failing vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | vector driven, waiting SETTLE cycles for the DUT to settle
// CHECK  | compare DUT against golden add, then advance or finish
// DONE   | sweep ended, results held until next start
module adder_nbit_tb_seq_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    adder_nbit_tb_seq_driver_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W-1:0]           fail_count,
    output logic [2*WIDTH:0]           first_fail_vec,
    output logic                       first_fail_valid
);
    localparam int VEC_W  = 2*WIDTH + 1;
    localparam int CNT_SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_SW-1:0] SETTLE_LD = CNT_SW'(SETTLE);

    typedef enum logic [1:0] {IDLE, SETTLE_ST, CHECK, DONE} state_t;

    state_t             state, state_next;
    logic [VEC_W-1:0]   vec;
    logic [CNT_SW-1:0]  settle_cnt;
    logic [WIDTH:0]     expected;
    logic               mismatch;
    logic               last_vec;
    logic               clear;
    logic               advance;
    logic               check_en;

    assign bus.c_in   = vec[VEC_W-1];
    assign bus.A_data = vec[2*WIDTH-1:WIDTH];
    assign bus.B_data = vec[WIDTH-1:0];

    assign expected = {1'b0, bus.A_data} + {1'b0, bus.B_data} + (WIDTH+1)'(bus.c_in);
    assign mismatch = (bus.sum != expected[WIDTH-1:0]) || (bus.c_out != expected[WIDTH]);
    assign last_vec = &vec;

    assign busy = (state == SETTLE_ST) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        advance    = 1'b0;
        check_en   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = SETTLE_ST;
                end
            end
            SETTLE_ST: begin
                if (settle_cnt <= CNT_SW'(1)) state_next = CHECK;
            end
            CHECK: begin
                check_en = 1'b1;
`ifdef STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
                    state_next = DONE;
                end else begin
                    advance    = 1'b1;
                    state_next = SETTLE_ST;
                end
`else
                if (last_vec) begin
                    state_next = DONE;
                end else begin
                    advance    = 1'b1;
                    state_next = SETTLE_ST;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec              <= '0;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (clear) begin
                vec              <= '0;
                settle_cnt       <= SETTLE_LD;
                pass             <= 1'b0;
                fail_count       <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
            end
            if (state == SETTLE_ST) settle_cnt <= settle_cnt - CNT_SW'(1);
            if (check_en) begin
                if (mismatch) begin
                    if (~&fail_count) fail_count <= fail_count + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                end
                // pass is resolved on the final check so it already reflects this vector
                if (state_next == DONE) pass <= !(first_fail_valid || mismatch);
            end
            if (advance) begin
                vec        <= vec + VEC_W'(1);
                settle_cnt <= SETTLE_LD;
            end
        end
    end
endmodule

// File: tb/tb_adder_nbit_tb_seq_driver.sv
// Bench for the adder sweep driver: behavioural adder with injectable faults, table-driven sweeps,
// plus mid-sweep reset, start-while-busy and restart-from-DONE sequences.
module tb_adder_nbit_tb_seq_driver;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;
    localparam int FULL   = (1 << (2*WIDTH+1)) * (SETTLE+1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy, done, pass, first_fail_valid;
    logic [CNT_W-1:0] fail_count;
    logic [2*WIDTH:0] first_fail_vec;
    int               fault_mode;
    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH:0]   raw;

    adder_nbit_tb_seq_driver_if #(.WIDTH(WIDTH)) bus ();

    adder_nbit_tb_seq_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;

    // Adder under test; mode 1 = c_out stuck-at-0, mode 2 = sum[0] stuck-at-0
    assign raw       = {1'b0, bus.A_data} + {1'b0, bus.B_data} + (WIDTH+1)'(bus.c_in);
    assign bus.c_out = (fault_mode == 1) ? 1'b0 : raw[WIDTH];
    assign bus.sum   = (fault_mode == 2) ? {raw[WIDTH-1:1], 1'b0} : raw[WIDTH-1:0];

    typedef struct {
        int         fault;
        int         exp_cycles;
        int         exp_fail;
        logic [8:0] exp_ffv;
        logic       exp_ffvalid;
        logic       exp_pass;
        logic [8:0] exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
        n_checks++;
        if (actual !== expect_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expect_v);
        end
    endtask

    // Pulse start for one edge; returns with time #1 after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    vec_t tbl[3];
    int   cyc;

    initial begin
        tbl[0] = '{0, FULL, 0,   9'h000, 1'b0, 1'b1, 9'h1FF};
`ifdef STOP_ON_FAIL_EN
        tbl[1] = '{1, 96,   1,   9'h01F, 1'b1, 1'b0, 9'h01F};
        tbl[2] = '{2, 6,    1,   9'h001, 1'b1, 1'b0, 9'h001};
`else
        tbl[1] = '{1, FULL, 256, 9'h01F, 1'b1, 1'b0, 9'h1FF};
        tbl[2] = '{2, FULL, 256, 9'h001, 1'b1, 1'b0, 9'h1FF};
`endif
        reset      = 1'b1;
        start      = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_vec", 32'({bus.c_in, bus.A_data, bus.B_data}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            fault_mode = tbl[i].fault;
            pulse_start();
            check("busy_after_start", 32'(busy), 32'd1);
            wait_done(cyc);
            check("sweep_cycles", 32'(cyc), 32'(tbl[i].exp_cycles));
            check("sweep_done", 32'(done), 32'd1);
            check("sweep_busy", 32'(busy), 32'd0);
            check("sweep_pass", 32'(pass), 32'(tbl[i].exp_pass));
            check("sweep_fail_count", 32'(fail_count), 32'(tbl[i].exp_fail));
            check("sweep_ff_valid", 32'(first_fail_valid), 32'(tbl[i].exp_ffvalid));
            check("sweep_ff_vec", 32'(first_fail_vec), 32'(tbl[i].exp_ffv));
            check("sweep_last_vec", 32'({bus.c_in, bus.A_data, bus.B_data}), 32'(tbl[i].exp_last));
        end

        // Reset mid-sweep with a faulty adder so the counters are non-zero beforehand
        fault_mode = 1;
        pulse_start();
        repeat (700) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_done", 32'(done), 32'd0);
        check("mid_reset_pass", 32'(pass), 32'd0);
        check("mid_reset_fail_count", 32'(fail_count), 32'd0);
        check("mid_reset_ff_valid", 32'(first_fail_valid), 32'd0);
        check("mid_reset_ff_vec", 32'(first_fail_vec), 32'd0);
        check("mid_reset_vec", 32'({bus.c_in, bus.A_data, bus.B_data}), 32'd0);
        fault_mode = 0;
        pulse_start();
        wait_done(cyc);
        check("post_reset_cycles", 32'(cyc), 32'(FULL));
        check("post_reset_pass", 32'(pass), 32'd1);

        // start while busy must be ignored
        pulse_start();
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (cyc == 100) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("busy_start_cycles", 32'(cyc), 32'(FULL));
        check("busy_start_pass", 32'(pass), 32'd1);

        // Failing sweep, then restart from DONE with a good adder
        fault_mode = 1;
        pulse_start();
        wait_done(cyc);
        check("restart_pre_pass", 32'(pass), 32'd0);
        fault_mode = 0;
        pulse_start();
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_fail_clr", 32'(fail_count), 32'd0);
        check("restart_ff_clr", 32'(first_fail_valid), 32'd0);
        check("restart_pass_clr", 32'(pass), 32'd0);
        wait_done(cyc);
        check("restart_cycles", 32'(cyc), 32'(FULL));
        check("restart_pass", 32'(pass), 32'd1);
        check("restart_fail_count", 32'(fail_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
